// File: rtl/detection_display_scheduler.sv
// Time-shares a 4-digit seven-segment display between front/side detection status and a
// saturating criminal-event counter, with per-sensor minimum hold time and fixed-rate scanning.
module detection_display_scheduler #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned HOLD_CYCLES = 200000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] Ffreq,
    input  logic [1:0] Sfreq,
    input  logic       clear,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int unsigned   PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [31:0]   HOLD_LOAD = 32'(HOLD_CYCLES - 1);

    typedef enum logic {StIdle, StHold} hold_state_e;

    logic [1:0]  r_q     [2];
    logic [1:0]  r_prev  [2];
    hold_state_e r_state [2];
    logic [1:0]  r_held  [2];
    logic [31:0] r_timer [2];
    logic [7:0]  r_cnt;
    logic [PW-1:0] r_pre;
    logic [1:0]  r_idx;

    logic [1:0]  w_code_in [2];
    logic [1:0]  w_rise;
    logic [8:0]  w_cnt_sum;
    logic [3:0]  w_an;
    logic [6:0]  w_seg;
    logic        w_dp;

    function automatic logic [6:0] f_hex(input logic [3:0] v);
        case (v)
            4'h0: f_hex = 7'b1000000;
            4'h1: f_hex = 7'b1111001;
            4'h2: f_hex = 7'b0100100;
            4'h3: f_hex = 7'b0110000;
            4'h4: f_hex = 7'b0011001;
            4'h5: f_hex = 7'b0010010;
            4'h6: f_hex = 7'b0000010;
            4'h7: f_hex = 7'b1111000;
            4'h8: f_hex = 7'b0000000;
            4'h9: f_hex = 7'b0010000;
            4'hA: f_hex = 7'b0001000;
            4'hB: f_hex = 7'b0000011;
            4'hC: f_hex = 7'b1000110;
            4'hD: f_hex = 7'b0100001;
            4'hE: f_hex = 7'b0000110;
            default: f_hex = 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] f_status(input logic [1:0] held);
        case (held)
            2'd2:    f_status = 7'b1000110;
            2'd1:    f_status = 7'b0001110;
            default: f_status = 7'b0111111;
        endcase
    endfunction

    // Reserved code 3 is folded to "none" before it reaches any state.
    always_comb begin
        w_code_in[0] = (Ffreq == 2'd3) ? 2'd0 : Ffreq;
        w_code_in[1] = (Sfreq == 2'd3) ? 2'd0 : Sfreq;
        for (int i = 0; i < 2; i++) begin
            w_rise[i] = (r_q[i] == 2'd2) && (r_prev[i] != 2'd2);
        end
        w_cnt_sum = {1'b0, r_cnt} + 9'(w_rise[0]) + 9'(w_rise[1]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_q[i]    <= 2'd0;
                r_prev[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_q[i]    <= w_code_in[i];
                r_prev[i] <= r_q[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= StIdle;
                r_held[i]  <= 2'd0;
                r_timer[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (clear) begin
                    r_state[i] <= StIdle;
                    r_held[i]  <= 2'd0;
                    r_timer[i] <= 32'd0;
                end else begin
                    case (r_state[i])
                        StIdle: begin
                            if (r_q[i] != 2'd0) begin
                                r_state[i] <= StHold;
                                r_held[i]  <= r_q[i];
                                r_timer[i] <= HOLD_LOAD;
                            end
                        end
                        default: begin
                            // Same code refreshes; criminal upgrades friendly, never the reverse.
                            if (r_q[i] == r_held[i] ||
                                (r_q[i] == 2'd2 && r_held[i] == 2'd1)) begin
                                r_held[i]  <= r_q[i];
                                r_timer[i] <= HOLD_LOAD;
                            end else if (r_timer[i] == 32'd0) begin
                                r_state[i] <= StIdle;
                                r_held[i]  <= 2'd0;
                            end else begin
                                r_timer[i] <= r_timer[i] - 32'd1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
        end else if (clear) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_comb begin
        w_an = ~(4'b0001 << r_idx);
        w_dp = !((r_idx == 2'd3) && (r_cnt == 8'hFF));
        case (r_idx)
            2'd0:    w_seg = f_status(r_held[0]);
            2'd1:    w_seg = f_status(r_held[1]);
            2'd2:    w_seg = f_hex(r_cnt[3:0]);
            default: w_seg = f_hex(r_cnt[7:4]);
        endcase
    end

    // Enables and segments share one register so they switch on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= w_an;
            seg <= w_seg;
            dp  <= w_dp;
        end
    end
endmodule

// File: tb/tb_detection_display_scheduler.sv
// Directed bench for detection_display_scheduler: a time-based behavioural model is compared
// against the display pins every cycle, plus literal spot checks on selected digits.
module tb_detection_display_scheduler;
    localparam int DIV = 4;
    localparam int H   = 10;
    localparam logic [6:0] GDASH = 7'b0111111;
    localparam logic [6:0] GF    = 7'b0001110;
    localparam logic [6:0] GC    = 7'b1000110;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] Ffreq   = 2'd0;
    logic [1:0] Sfreq   = 2'd0;
    logic       clear   = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad   = 0;

    // Model: n = edges since reset release; each sensor remembers held code and last refresh edge.
    int n = 0;
    int m_held [2] = '{0, 0};
    int m_last [2] = '{0, 0};
    int m_q    [2] = '{0, 0};
    int m_prev [2] = '{0, 0};
    int m_cnt = 0;
    logic [3:0] e_an  = 4'b1111;
    logic [6:0] e_seg = 7'b1111111;
    logic       e_dp  = 1'b1;

    detection_display_scheduler #(
        .REFRESH_DIV(DIV),
        .HOLD_CYCLES(H)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .Ffreq  (Ffreq),
        .Sfreq  (Sfreq),
        .clear  (clear),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [6:0] hex_glyph(input int v);
        case (v)
            0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
            3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
            9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
           12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] status_glyph(input int h);
        if (h == 2) return GC;
        if (h == 1) return GF;
        return GDASH;
    endfunction

    function automatic int map_code(input logic [1:0] c);
        return (c == 2'd3) ? 0 : int'(c);
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            n = 0;
            m_cnt = 0;
            for (int i = 0; i < 2; i++) begin
                m_held[i] = 0; m_last[i] = 0; m_q[i] = 0; m_prev[i] = 0;
            end
            e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
        end else begin
            int idx;
            int inc;
            n++;
            idx = ((n - 1) / DIV) % 4;
            e_an = ~(4'b0001 << idx);
            e_dp = !(idx == 3 && m_cnt == 255);
            case (idx)
                0: e_seg = status_glyph(m_held[0]);
                1: e_seg = status_glyph(m_held[1]);
                2: e_seg = hex_glyph(m_cnt % 16);
                default: e_seg = hex_glyph(m_cnt / 16);
            endcase
            inc = 0;
            for (int i = 0; i < 2; i++) begin
                if (m_q[i] == 2 && m_prev[i] != 2) inc++;
                if (clear) begin
                    m_held[i] = 0;
                end else if (m_held[i] == 0) begin
                    if (m_q[i] != 0) begin m_held[i] = m_q[i]; m_last[i] = n; end
                end else if (m_q[i] == m_held[i] || (m_q[i] == 2 && m_held[i] == 1)) begin
                    m_held[i] = m_q[i]; m_last[i] = n;
                end else if (n - m_last[i] >= H) begin
                    m_held[i] = 0;
                end
            end
            m_cnt = clear ? 0 : ((m_cnt + inc > 255) ? 255 : m_cnt + inc);
            for (int i = 0; i < 2; i++) m_prev[i] = m_q[i];
            m_q[0] = map_code(Ffreq);
            m_q[1] = map_code(Sfreq);
        end
    end

    initial forever begin
        @(negedge clock);
        if (reset_n) check("scan", {an, seg, dp}, {e_an, e_seg, e_dp});
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic wait_digit(input int d, input logic [6:0] s, input logic p, input string name);
        logic [3:0] en;
        logic found;
        en = ~(4'b0001 << d);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clock);
            if (an == en) found = 1'b1;
        end
        check(name, {an, seg, dp}, {en, s, p});
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 check("reset_hold", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1 check("first_edge", {an, seg, dp}, {4'b1110, GDASH, 1'b1});
        tick(20);
        wait_digit(1, GDASH, 1'b1, "idle_d1");
        wait_digit(2, 7'b1000000, 1'b1, "idle_d2");
        wait_digit(3, 7'b1000000, 1'b1, "idle_d3");

        // One-cycle friendly pulses swept across all scan phases to expose the expiry edge.
        for (int off = 1; off <= 16; off++) begin
            tick(off);
            Ffreq = 2'd1; Sfreq = 2'd1;
            tick(1);
            Ffreq = 2'd0; Sfreq = 2'd0;
            tick(20);
        end
        wait_digit(0, GDASH, 1'b1, "hold_expired");

        Ffreq = 2'd1;
        tick(8);
        wait_digit(0, GF, 1'b1, "front_F");
        Ffreq = 2'd2;
        tick(3);
        wait_digit(0, GC, 1'b1, "front_C");
        Ffreq = 2'd1;
        tick(30);
        check("model_cnt_one", 12'(m_cnt), 12'd1);
        wait_digit(2, 7'b1111001, 1'b1, "cnt_one");
        Ffreq = 2'd0;
        tick(20);

        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(3);
        Ffreq = 2'd2; Sfreq = 2'd2;
        tick(50);
        check("model_cnt_two", 12'(m_cnt), 12'd2);
        wait_digit(2, 7'b0100100, 1'b1, "cnt_two");
        wait_digit(3, 7'b1000000, 1'b1, "cnt_two_hi");
        Ffreq = 2'd0; Sfreq = 2'd0;
        tick(2);

        for (int k = 0; k < 130; k++) begin
            Ffreq = 2'd2; Sfreq = 2'd2;
            tick(1);
            Ffreq = 2'd0; Sfreq = 2'd0;
            tick(1);
        end
        tick(3);
        check("model_cnt_sat", 12'(m_cnt), 12'd255);
        wait_digit(2, GF, 1'b1, "sat_lo");
        wait_digit(3, GF, 1'b0, "sat_hi_dp");
        tick(20);

        // Clear lands on the same edge as the side rising edge.
        Sfreq = 2'd2;
        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(5);
        check("model_cnt_clr", 12'(m_cnt), 12'd0);
        wait_digit(2, 7'b1000000, 1'b1, "clr_cnt");
        wait_digit(1, GC, 1'b1, "clr_side_hold");
        Sfreq = 2'd0;
        Ffreq = 2'd3;
        tick(30);
        wait_digit(0, GDASH, 1'b1, "reserved_front");
        wait_digit(2, 7'b1000000, 1'b1, "reserved_nocnt");

        Ffreq = 2'd1;
        tick(5);
        #2 reset_n = 1'b0;
        #1 check("async_reset", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1 check("first_edge_again", {an, seg, dp}, {4'b1110, GDASH, 1'b1});
        tick(20);
        Ffreq = 2'd0;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/detection_display_scheduler.md
# detection_display_scheduler

Scheduler for the rover's 4-digit seven-segment display that time-shares it between the front (`Ffreq`) and side (`Sfreq`) detectors and a criminal-event counter. Holds each sensor's detection for a minimum visible time and scans the digits at a fixed refresh rate. Sits between the frequency-classification blocks and the board display pins, and replaces direct single-digit driving.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 ms at 100 MHz).
- `HOLD_CYCLES`, 200000000: minimum cycles a detection stays shown after its last occurrence (2 s).

- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `Ffreq`  in  2  front code: 0 none, 1 friendly, 2 criminal, 3 reserved (treated as 0).
- `Sfreq`  in  2  side code, same encoding.
- `clear`  in  1  synchronous pulse: clears holds and counter.
- `an`  out  4  digit enables, active low.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active low.
- `dp`  out  1  decimal point, active low.

## Operation
- Input stage: `Ffreq`/`Sfreq` are registered once (`f_q`, `s_q`). All logic uses the registered values.
- Per-sensor hold FSM, states IDLE and HOLD, with `held` (2 bits) and `timer` (32 bits):
  - IDLE, code 1 or 2 → HOLD, `held`=code, `timer`=HOLD_CYCLES-1.
  - HOLD, code == `held` → reload `timer`=HOLD_CYCLES-1.
  - HOLD, code 2 while `held`=1 → upgrade: `held`=2, reload.
  - HOLD, code 1 while `held`=2 → ignored; timer keeps decrementing.
  - HOLD, no reload and `timer`==0 → IDLE, `held`=0. Otherwise `timer` decrements.
- Criminal counter `cnt` (8 bits):
  - +1 per sensor on each rising edge of (code==2) in the registered input, i.e. previous value !=2 and current ==2.
  - Both sensors rising in the same cycle → +2.
  - Saturates at 0xFF and never wraps. A +2 from 0xFE or 0xFF gives 0xFF.
- `clear` has priority over every simultaneous event: both FSMs → IDLE, `cnt`=0. Input and edge registers are not cleared.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1.
  - At terminal count, digit index `idx` advances 0→1→2→3→0.
- Digit contents:
  - idx0: front status.
  - idx1: side status.
  - idx2: `cnt[3:0]`.
  - idx3: `cnt[7:4]`.
- `an`: idx0=1110, idx1=1101, idx2=1011, idx3=0111.
- Status glyphs: `held`=2 → C 1000110; `held`=1 → F 0001110; IDLE → dash 0111111.
- Hex glyphs, in order 0–F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- `dp`: 0 only when idx==3 and `cnt`==0xFF (saturation flag); 1 otherwise.

## Timing
- Reset values while `reset_n`=0:
  - `an`=1111, `seg`=1111111, `dp`=1.
  - `idx`=0, prescaler=0, `cnt`=0, both FSMs IDLE, input registers 0.
- `an`, `seg` and `dp` are registered from `idx` and state. On the first rising edge after reset release: `an`=1110, `seg`=0111111.
- Latency:
  - Input change to FSM/counter update: 2 edges.
  - FSM/counter update to `seg`, when the digit is selected: 1 further edge.
  - Total 3 cycles.
- Digit period is REFRESH_DIV cycles. `an` and `seg` change on the same edge, so no ghosting cycle.
- Hold expiry: the status returns to dash exactly HOLD_CYCLES+1 edges after the last cycle with a matching registered code (the last reload), then 1 output-register edge.
- Asserting reset mid-scan or mid-hold immediately forces the reset values asynchronously.
- `clear` takes effect on the next edge. A code present during `clear` restarts the FSM on the following cycle.

## Test plan
- Reset, then idle inputs with REFRESH_DIV=4: `an` cycles 1110→1101→1011→0111 every 4 cycles; `seg`=0111111 on idx0/1 and 1000000 on idx2/3; `dp`=1.
- HOLD_CYCLES=10, `Ffreq`=1 for 1 cycle: digit0 shows 0001110. It returns to 0111111 exactly 11 cycles after the FSM update.
- `Ffreq`=1 held, then 2: digit0 changes F→C and `cnt`=1. `Ffreq`=1 afterwards keeps C until the timer expires.
- `Ffreq` and `Sfreq` go 0→2 in the same cycle: `cnt`=2 and digit2 shows 0100100. Holding 2 for 50 cycles causes no further increment.
- 130 simultaneous double rising edges: `cnt` saturates at 0xFF; digits 2/3 show 0001110; `dp`=0 on idx3 only.
- `clear` in the same cycle as a `Sfreq` 0→2 edge: `cnt`=0 and side shows dash. A held `Sfreq`=2 re-enters HOLD the next cycle without incrementing `cnt`, since there is no new edge.
